// File: rtl/onehot_mon_if.sv
// onehot_mon_if -- bundle of the sampled vector, its controls and the
// status returned by the onehot_mon checker.
//   master : drives en/clr/strict/vec, observes status (bench or host logic)
//   slave  : the checker itself
// Signals:
//   en, clr, strict  sample enable, synchronous clear, onehot(1)/onehot0(0)
//   vec              monitored vector
//   viol             last enabled sample was illegal (registered pulse)
//   err_sticky       a violation has been seen since rst/clr
//   fatal            RUN_LIMIT consecutive violations seen since rst/clr
//   err_cnt/chk_cnt  saturating violation / sample counters
//   first_vec        vector of the first violation
//   first_cyc        chk_cnt value at the first violation
//   state            0 IDLE, 1 ARMED, 2 FAILED, 3 FATAL
interface onehot_mon_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             en;
  logic             clr;
  logic             strict;
  logic [WIDTH-1:0] vec;
  logic             viol;
  logic             err_sticky;
  logic             fatal;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] chk_cnt;
  logic [WIDTH-1:0] first_vec;
  logic [CNT_W-1:0] first_cyc;
  logic [1:0]       state;

  modport master (
    output en, clr, strict, vec,
    input  viol, err_sticky, fatal, err_cnt, chk_cnt, first_vec, first_cyc, state
  );

  modport slave (
    input  en, clr, strict, vec,
    output viol, err_sticky, fatal, err_cnt, chk_cnt, first_vec, first_cyc, state
  );
endinterface

// File: rtl/onehot_mon.sv
// onehot_mon -- run-time onehot / onehot0 checker for an N-bit vector.
// Counts enabled samples and violations (saturating), captures the first
// violation, and escalates to FATAL after RUN_LIMIT consecutive illegal
// samples. Everything is cleared by rst (priority) or clr.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   mon  onehot_mon_if slave modport (controls in, status out)
module onehot_mon #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 16,
  parameter int RUN_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  onehot_mon_if.slave   mon
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int RUN_W = $clog2(RUN_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    FAILED = 2'd2,
    FATAL  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  popcnt;
  logic             legal;
  logic [RUN_W-1:0] run_q, run_d;
  logic             viol_q;
  logic [CNT_W-1:0] err_cnt_q, chk_cnt_q, first_cyc_q;
  logic [WIDTH-1:0] first_vec_q;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt = popcnt + PC_W'(mon.vec[i]);
    end
  end

  assign legal = mon.strict ? (popcnt == PC_W'(1)) : (popcnt <= PC_W'(1));

  // Run length of consecutive illegal samples; idle cycles leave it alone.
  always_comb begin
    run_d = run_q;
    if (mon.en) begin
      if (legal)                run_d = '0;
      else if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (mon.en) begin
      case (state_q)
        IDLE, ARMED: begin
          if (legal)               state_d = ARMED;
          else if (run_d == RUN_MAX) state_d = FATAL;
          else                     state_d = FAILED;
        end
        FAILED:  if (run_d == RUN_MAX) state_d = FATAL;
        FATAL:   state_d = FATAL;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (rst || mon.clr) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || mon.clr) begin
      run_q       <= '0;
      viol_q      <= 1'b0;
      err_cnt_q   <= '0;
      chk_cnt_q   <= '0;
      first_vec_q <= '0;
      first_cyc_q <= '0;
    end else if (mon.en) begin
      run_q  <= run_d;
      viol_q <= !legal;
      if (chk_cnt_q != '1) chk_cnt_q <= chk_cnt_q + CNT_W'(1);
      if (!legal) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
        // IDLE/ARMED means no violation has been seen yet: this is the first.
        if (state_q == IDLE || state_q == ARMED) begin
          first_vec_q <= mon.vec;
          first_cyc_q <= chk_cnt_q;
        end
      end
    end else begin
      viol_q <= 1'b0;
    end
  end

  assign mon.viol       = viol_q;
  assign mon.err_sticky = (state_q == FAILED) || (state_q == FATAL);
  assign mon.fatal      = (state_q == FATAL);
  assign mon.err_cnt    = err_cnt_q;
  assign mon.chk_cnt    = chk_cnt_q;
  assign mon.first_vec  = first_vec_q;
  assign mon.first_cyc  = first_cyc_q;
  assign mon.state      = state_q;

endmodule

// File: tb/tb_onehot_mon.sv
// tb_onehot_mon -- directed scenarios plus randomized run against a
// behavioural model, for onehot_mon with WIDTH=4, CNT_W=4, RUN_LIMIT=3.
module tb_onehot_mon;
  localparam int W    = 4;
  localparam int CW   = 4;
  localparam int RL   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  onehot_mon_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  onehot_mon #(.WIDTH(W), .CNT_W(CW), .RUN_LIMIT(RL)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integers and flags derived from the rules.
  int         m_chk, m_err, m_run, m_fcyc;
  bit         m_viol, m_started, m_err_seen, m_fatal;
  logic [3:0] m_fvec;

  function automatic logic [1:0] exp_state();
    if (m_fatal)         return 2'd3;
    else if (m_err_seen) return 2'd2;
    else if (m_started)  return 2'd1;
    else                 return 2'd0;
  endfunction

  task automatic model_clear();
    m_chk = 0; m_err = 0; m_run = 0; m_fcyc = 0; m_fvec = '0;
    m_viol = 0; m_started = 0; m_err_seen = 0; m_fatal = 0;
  endtask

  // Drive one cycle, update the model at the edge, return #1 after it.
  task automatic apply(input logic r, input logic c, input logic e,
                       input logic s, input logic [3:0] v);
    bit lg;
    rst = r; bus.clr = c; bus.en = e; bus.strict = s; bus.vec = v;
    @(posedge clk);
    if (r || c) model_clear();
    else if (e) begin
      lg = s ? ($countones(v) == 1) : ($countones(v) <= 1);
      m_viol = !lg;
      m_started = 1;
      if (!lg && !m_err_seen) begin
        m_err_seen = 1; m_fvec = v; m_fcyc = m_chk;
      end
      if (m_chk < CMAX) m_chk++;
      if (!lg) begin
        if (m_err < CMAX) m_err++;
        if (m_run < RL) m_run++;
        if (m_run == RL) m_fatal = 1;
      end else m_run = 0;
    end else m_viol = 0;
    #1;
  endtask

  task automatic clear();
    apply(0, 1, 0, 0, 4'b0000);
  endtask

  task automatic test_reset();
    apply(1, 0, 1, 1, 4'b1111);
    vectors++;
    if ({bus.viol, bus.err_sticky, bus.fatal, bus.err_cnt, bus.chk_cnt,
         bus.first_vec, bus.first_cyc} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got viol=%b sticky=%b fatal=%b err=%0d chk=%0d fv=%b fc=%0d, want all 0",
               bus.viol, bus.err_sticky, bus.fatal, bus.err_cnt, bus.chk_cnt, bus.first_vec, bus.first_cyc);
    end
    vectors++;
    if (bus.state !== 2'd0) begin
      miscompares++; $display("FAIL reset_state: got %0d want 0", bus.state);
    end
  endtask

  task automatic test_onehot0_legal();
    logic [3:0] seq [4] = '{4'b0000, 4'b0001, 4'b0100, 4'b1000};
    clear();
    foreach (seq[i]) begin
      apply(0, 0, 1, 0, seq[i]);
      vectors++;
      if (bus.viol !== 1'b0) begin
        miscompares++; $display("FAIL onehot0_viol[%0d]: got %b want 0", i, bus.viol);
      end
    end
    vectors++;
    if (bus.chk_cnt !== 4'd4 || bus.err_cnt !== 4'd0 || bus.state !== 2'd1) begin
      miscompares++;
      $display("FAIL onehot0_status: got chk=%0d err=%0d st=%0d want 4 0 1", bus.chk_cnt, bus.err_cnt, bus.state);
    end
  endtask

  task automatic test_first_capture();
    clear();
    apply(0, 0, 1, 0, 4'b0010);
    vectors++;
    if (bus.viol !== 1'b0) begin
      miscompares++; $display("FAIL capture_pre_viol: got %b want 0", bus.viol);
    end
    apply(0, 0, 1, 0, 4'b0110);
    vectors++;
    if (bus.viol !== 1'b1 || bus.err_sticky !== 1'b1 || bus.state !== 2'd2) begin
      miscompares++;
      $display("FAIL capture_flags: got viol=%b sticky=%b st=%0d want 1 1 2", bus.viol, bus.err_sticky, bus.state);
    end
    vectors++;
    if (bus.first_vec !== 4'b0110 || bus.first_cyc !== 4'd1) begin
      miscompares++;
      $display("FAIL capture_data: got fv=%b fc=%0d want 0110 1", bus.first_vec, bus.first_cyc);
    end
  endtask

  task automatic test_strict();
    clear();
    apply(0, 0, 1, 1, 4'b0000);
    vectors++;
    if (bus.viol !== 1'b1 || bus.err_cnt !== 4'd1) begin
      miscompares++; $display("FAIL strict_zero: got viol=%b err=%0d want 1 1", bus.viol, bus.err_cnt);
    end
    clear();
    apply(0, 0, 1, 0, 4'b0000);
    vectors++;
    if (bus.viol !== 1'b0 || bus.err_cnt !== 4'd0 || bus.state !== 2'd1) begin
      miscompares++;
      $display("FAIL lenient_zero: got viol=%b err=%0d st=%0d want 0 0 1", bus.viol, bus.err_cnt, bus.state);
    end
  endtask

  task automatic test_run_fatal();
    clear();
    apply(0, 0, 1, 0, 4'b1100);
    apply(0, 0, 1, 0, 4'b1100);
    apply(0, 0, 0, 0, 4'b1100);
    vectors++;
    if (bus.viol !== 1'b0) begin
      miscompares++; $display("FAIL run_gap_viol: got %b want 0", bus.viol);
    end
    apply(0, 0, 0, 0, 4'b0000);
    vectors++;
    if (bus.fatal !== 1'b0) begin
      miscompares++; $display("FAIL run_early_fatal: got %b want 0", bus.fatal);
    end
    apply(0, 0, 1, 0, 4'b1100);
    vectors++;
    if (bus.fatal !== 1'b1 || bus.err_cnt !== 4'd3 || bus.first_vec !== 4'b1100 || bus.state !== 2'd3) begin
      miscompares++;
      $display("FAIL run_fatal: got fatal=%b err=%0d fv=%b st=%0d want 1 3 1100 3",
               bus.fatal, bus.err_cnt, bus.first_vec, bus.state);
    end
  endtask

  task automatic test_run_broken();
    clear();
    apply(0, 0, 1, 0, 4'b1100);
    apply(0, 0, 1, 0, 4'b1100);
    apply(0, 0, 1, 0, 4'b0001);
    apply(0, 0, 1, 0, 4'b1100);
    vectors++;
    if (bus.fatal !== 1'b0 || bus.err_cnt !== 4'd3 || bus.state !== 2'd2) begin
      miscompares++;
      $display("FAIL run_broken: got fatal=%b err=%0d st=%0d want 0 3 2", bus.fatal, bus.err_cnt, bus.state);
    end
  endtask

  task automatic test_saturation();
    clear();
    repeat (20) apply(0, 0, 1, 0, 4'b1111);
    vectors++;
    if (bus.err_cnt !== 4'd15 || bus.chk_cnt !== 4'd15 || bus.first_cyc !== 4'd0 || bus.state !== 2'd3) begin
      miscompares++;
      $display("FAIL saturation: got err=%0d chk=%0d fc=%0d st=%0d want 15 15 0 3",
               bus.err_cnt, bus.chk_cnt, bus.first_cyc, bus.state);
    end
  endtask

  // Runs from the FATAL state left by test_saturation.
  task automatic test_clr_discard();
    apply(0, 1, 1, 0, 4'b1111);
    vectors++;
    if ({bus.viol, bus.err_sticky, bus.fatal, bus.err_cnt, bus.chk_cnt,
         bus.first_vec, bus.first_cyc, bus.state} !== '0) begin
      miscompares++;
      $display("FAIL clr_discard: got viol=%b err=%0d chk=%0d fv=%b st=%0d want all 0",
               bus.viol, bus.err_cnt, bus.chk_cnt, bus.first_vec, bus.state);
    end
  endtask

  task automatic test_rst_in_fatal();
    clear();
    repeat (3) apply(0, 0, 1, 0, 4'b1111);
    vectors++;
    if (bus.state !== 2'd3) begin
      miscompares++; $display("FAIL rst_setup_fatal: got st=%0d want 3", bus.state);
    end
    apply(1, 0, 1, 0, 4'b1111);
    vectors++;
    if ({bus.viol, bus.err_sticky, bus.fatal, bus.err_cnt, bus.chk_cnt,
         bus.first_vec, bus.first_cyc, bus.state} !== '0) begin
      miscompares++;
      $display("FAIL rst_in_fatal: got viol=%b err=%0d chk=%0d fv=%b st=%0d want all 0",
               bus.viol, bus.err_cnt, bus.chk_cnt, bus.first_vec, bus.state);
    end
  endtask

  task automatic test_random();
    logic [20:0] got, exp;
    logic [3:0]  v;
    clear();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 2))
        0:       v = 4'($urandom);
        1:       v = 4'b0001 << $urandom_range(0, 3);
        default: v = 4'b0000;
      endcase
      apply(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 49) == 0),
            logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)), v);
      got = {bus.viol, bus.err_sticky, bus.fatal, bus.err_cnt, bus.chk_cnt,
             bus.first_vec, bus.first_cyc, bus.state};
      exp = {m_viol, exp_state() >= 2'd2, exp_state() == 2'd3, 4'(m_err), 4'(m_chk),
             m_fvec, 4'(m_fcyc), exp_state()};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random[%0d]: got %b want %b (viol,sticky,fatal,err,chk,fvec,fcyc,state)", n, got, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.clr = 1'b0; bus.en = 1'b0; bus.strict = 1'b0; bus.vec = '0;
    model_clear();
    test_reset();
    test_onehot0_legal();
    test_first_capture();
    test_strict();
    test_run_fatal();
    test_run_broken();
    test_saturation();
    test_clr_discard();
    test_rst_in_fatal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
